vram_write_arbiter: RTL and testbench

- Owns the single VRAM write port (we/addr/data) of the 256x256x12 framebuffer.
- Shares the port between two requesters:
  - the pen requester, which writes one pixel per cycle while drawing;
  - a built-in rectangle-fill engine, which clears the screen or floods a region in row-major order.
- Sits between the pen controller and the dual-port VRAM, replacing the direct pen-to-VRAM write connection.

---
 rtl/vram_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_vram_write_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_arbiter.sv
// Owns the framebuffer write port. Pen writes take priority over a built-in
// row-major rectangle-fill engine, which gets a forced slot after a run of pen grants.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no fill pending; fill_start latches a rectangle
//   FILL  | fill walks the rectangle one pixel per owned cycle
//   DONE  | last pixel issued; fill_done pulses for one cycle
module vram_write_arbiter #(
    parameter int CW           = 8,
    parameter int DW           = 12,
    parameter int STARVE_LIMIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pen_we,
    input  logic [2*CW-1:0] pen_addr,
    input  logic [DW-1:0]   pen_data,
    output logic            pen_grant,
    input  logic            fill_start,
    input  logic [CW-1:0]   fill_x0,
    input  logic [CW-1:0]   fill_y0,
    input  logic [CW-1:0]   fill_x1,
    input  logic [CW-1:0]   fill_y1,
    input  logic [DW-1:0]   fill_color,
    input  logic            fill_abort,
    output logic            fill_busy,
    output logic            fill_done,
    output logic            we,
    output logic [2*CW-1:0] waddr,
    output logic [DW-1:0]   wdata
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_LOAD = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] x, y, xmin, xmax, ymax;
    logic [CW-1:0] xlo, xhi, ylo, yhi;
    logic [DW-1:0] color;
    logic [SW-1:0] starve_left;
    logic          in_fill, starved, fill_grant, at_last;

    always_comb begin
        xlo = (fill_x0 < fill_x1) ? fill_x0 : fill_x1;
        xhi = (fill_x0 < fill_x1) ? fill_x1 : fill_x0;
        ylo = (fill_y0 < fill_y1) ? fill_y0 : fill_y1;
        yhi = (fill_y0 < fill_y1) ? fill_y1 : fill_y0;
    end

    // Starvation counter runs down from the limit; terminal count forces a fill slot.
    always_comb begin
        in_fill    = (state == FILL);
        starved    = in_fill && (starve_left == '0);
        pen_grant  = rst && pen_we && !starved;
        fill_grant = in_fill && !pen_grant && !fill_abort;
        at_last    = (x == xmax) && (y == ymax);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (fill_start) state_next = FILL;
            FILL: begin
                if (fill_abort)                 state_next = IDLE;
                else if (fill_grant && at_last) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            state     <= state_next;
            fill_busy <= (state_next != IDLE);
            fill_done <= (state_next == DONE);
        end
    end

    // End of row is an equality test so xmax=255 never wraps into a spare column.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x     <= '0;
            y     <= '0;
            xmin  <= '0;
            xmax  <= '0;
            ymax  <= '0;
            color <= '0;
        end else if (state == IDLE && fill_start) begin
            xmin  <= xlo;
            xmax  <= xhi;
            ymax  <= yhi;
            x     <= xlo;
            y     <= ylo;
            color <= fill_color;
        end else if (fill_grant) begin
            if (x != xmax) begin
                x <= x + CW'(1);
            end else begin
                x <= xmin;
                y <= y + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_left <= STARVE_LOAD;
        end else if (!in_fill || state_next != FILL || !pen_we || fill_grant) begin
            starve_left <= STARVE_LOAD;
        end else if (pen_grant && starve_left != '0) begin
            starve_left <= starve_left - SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (pen_grant) begin
            we    <= 1'b1;
            waddr <= pen_addr;
            wdata <= pen_data;
        end else if (fill_grant) begin
            we    <= 1'b1;
            waddr <= {y, x};
            wdata <= color;
        end else begin
            we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: a queue-of-pixels reference model checked every
// cycle, a table of fill rectangles, hand sequences for corner cases, random traffic.
module tb_vram_write_arbiter;

    localparam int LIM = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pen_we = 1'b0;
    logic [15:0] pen_addr = '0;
    logic [11:0] pen_data = '0;
    logic        pen_grant;
    logic        fill_start = 1'b0;
    logic [7:0]  fill_x0 = '0, fill_y0 = '0, fill_x1 = '0, fill_y1 = '0;
    logic [11:0] fill_color = '0;
    logic        fill_abort = 1'b0;
    logic        fill_busy, fill_done, we;
    logic [15:0] waddr;
    logic [11:0] wdata;

    always #5 clk = ~clk;

    vram_write_arbiter #(.CW(8), .DW(12), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .pen_we(pen_we), .pen_addr(pen_addr), .pen_data(pen_data), .pen_grant(pen_grant),
        .fill_start(fill_start), .fill_x0(fill_x0), .fill_y0(fill_y0),
        .fill_x1(fill_x1), .fill_y1(fill_y1), .fill_color(fill_color),
        .fill_abort(fill_abort), .fill_busy(fill_busy), .fill_done(fill_done),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    int total = 0;
    int bad = 0;

    // Reference model: pending fill pixels as a queue, plus expected registered outputs.
    int q[$];
    int mdl_col, run;
    bit done_flag;
    int exp_we, exp_waddr, exp_wdata, exp_busy, exp_done;

    // Observations gathered while ticking.
    int obs_wc, obs_first, obs_last, obs_lastdata, obs_busyc, obs_donec;
    bit cur_busy, rec_addrs, last_pg;
    int obs_addrs[$];
    int gq[$];

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
            if (bad >= 40) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    endtask

    function automatic void mdl_reset();
        q.delete();
        run = 0; done_flag = 0; mdl_col = 0;
        exp_we = 0; exp_waddr = 0; exp_wdata = 0; exp_busy = 0; exp_done = 0;
    endfunction

    function automatic void clr_obs();
        obs_wc = 0; obs_first = -1; obs_last = -1; obs_lastdata = -1;
        obs_busyc = 0; obs_donec = 0; cur_busy = 0;
        obs_addrs.delete();
        gq.delete();
    endfunction

    function automatic void push_rect(int x0, int y0, int x1, int y1, int col);
        int xa = (x0 < x1) ? x0 : x1;
        int xb = (x0 < x1) ? x1 : x0;
        int ya = (y0 < y1) ? y0 : y1;
        int yb = (y0 < y1) ? y1 : y0;
        for (int yy = ya; yy <= yb; yy++)
            for (int xx = xa; xx <= xb; xx++)
                q.push_back(yy * 256 + xx);
        mdl_col = col;
    endfunction

    function automatic int clamp8(int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // One clock: check at negedge against the model, advance the model, return at posedge+1.
    task automatic tick();
        int  pg, fg;
        bit  filling, dn;
        @(negedge clk);
        chk("we", we, exp_we);
        if (exp_we != 0) begin
            chk("waddr", waddr, exp_waddr);
            chk("wdata", wdata, exp_wdata);
        end
        chk("fill_busy", fill_busy, exp_busy);
        chk("fill_done", fill_done, exp_done);
        filling = (q.size() > 0);
        pg = (pen_we && !(filling && run == LIM)) ? 1 : 0;
        chk("pen_grant", pen_grant, pg);
        last_pg = pen_grant;

        if (we) begin
            if (obs_wc == 0) obs_first = waddr;
            obs_last = waddr;
            obs_lastdata = wdata;
            obs_wc++;
            if (rec_addrs) obs_addrs.push_back(waddr);
        end
        if (fill_busy) obs_busyc++;
        if (fill_done) obs_donec++;
        cur_busy = fill_busy;
        if (fill_busy && !fill_done) gq.push_back(pen_grant);

        fg = (filling && pg == 0 && !fill_abort) ? 1 : 0;
        exp_we = (pg != 0 || fg != 0) ? 1 : 0;
        if (pg != 0) begin
            exp_waddr = pen_addr;
            exp_wdata = pen_data;
        end else if (fg != 0) begin
            exp_waddr = q.pop_front();
            exp_wdata = mdl_col;
        end
        run = (filling && pg != 0 && !fill_abort) ? ((run < LIM) ? run + 1 : LIM) : 0;
        dn = (fg != 0) && (q.size() == 0);
        if (filling && fill_abort)
            q.delete();
        else if (!filling && !done_flag && fill_start)
            push_rect(fill_x0, fill_y0, fill_x1, fill_y1, fill_color);
        done_flag = dn;
        exp_done = dn;
        exp_busy = (q.size() > 0 || dn) ? 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input int x0, input int y0, input int x1, input int y1,
                            input int col, input int bound);
        int n;
        fill_x0 = 8'(x0); fill_y0 = 8'(y0); fill_x1 = 8'(x1); fill_y1 = 8'(y1);
        fill_color = 12'(col);
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        n = 0;
        while (!(obs_busyc > 0 && !cur_busy) && n < bound) begin
            tick();
            n++;
        end
        chk("fill_within_bound", (n < bound) ? 1 : 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_waddr"}, waddr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_busy"}, fill_busy, 0);
        chk({tag, "_done"}, fill_done, 0);
        chk({tag, "_pen_grant"}, pen_grant, 0);
    endtask

    typedef struct {
        int x0, y0, x1, y1, col;
        int first, last, count, busy;
    } vec_t;

    vec_t vt[5];
    int   rev_exp[4];

    initial begin
        int n;
        int gz;
        vt[0] = '{x0:2,   y0:3,   x1:4,   y1:3,   col:'hF00, first:'h0302, last:'h0304, count:3,  busy:4};
        vt[1] = '{x0:5,   y0:5,   x1:4,   y1:4,   col:'h0A5, first:'h0404, last:'h0505, count:4,  busy:5};
        vt[2] = '{x0:7,   y0:9,   x1:7,   y1:9,   col:'h3C3, first:'h0907, last:'h0907, count:1,  busy:2};
        vt[3] = '{x0:255, y0:0,   x1:250, y1:1,   col:'h123, first:'h00FA, last:'h01FF, count:12, busy:13};
        vt[4] = '{x0:0,   y0:255, x1:1,   y1:254, col:'hFFF, first:'hFE00, last:'hFF01, count:4,  busy:5};
        rev_exp[0] = 'h0404; rev_exp[1] = 'h0405; rev_exp[2] = 'h0504; rev_exp[3] = 'h0505;

        mdl_reset();
        clr_obs();
        rec_addrs = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;

        // Table of rectangles, pen idle.
        for (int i = 0; i < 5; i++) begin
            clr_obs();
            run_fill(vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].col, 200);
            chk($sformatf("vec%0d_count", i), obs_wc, vt[i].count);
            chk($sformatf("vec%0d_first", i), obs_first, vt[i].first);
            chk($sformatf("vec%0d_last", i), obs_last, vt[i].last);
            chk($sformatf("vec%0d_color", i), obs_lastdata, vt[i].col);
            chk($sformatf("vec%0d_busy_cycles", i), obs_busyc, vt[i].busy);
            chk($sformatf("vec%0d_done_pulses", i), obs_donec, 1);
        end

        // Reversed corners, exact order.
        clr_obs();
        rec_addrs = 1;
        run_fill(5, 5, 4, 4, 'h777, 200);
        rec_addrs = 0;
        chk("rev_count", obs_addrs.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rev_addr%0d", k), (k < obs_addrs.size()) ? obs_addrs[k] : -1, rev_exp[k]);

        // Pen-only write with fill idle.
        pen_we = 1'b1; pen_addr = 16'h1234; pen_data = 12'hABC;
        #1;
        chk("pen_grant_same_cycle", pen_grant, 1);
        tick();
        pen_we = 1'b0; pen_addr = '0; pen_data = '0;
        chk("pen_we_next", we, 1);
        chk("pen_waddr_next", waddr, 'h1234);
        chk("pen_wdata_next", wdata, 'hABC);
        tick();

        // Pen held busy through a fill: 15 pen grants, then one forced fill slot.
        clr_obs();
        pen_we = 1'b1; pen_addr = 16'h8080; pen_data = 12'h555;
        run_fill(0, 0, 9, 1, 'h0F0, 2000);
        pen_we = 1'b0;
        tick();
        chk("starve_len", gq.size(), 320);
        gz = 0;
        foreach (gq[k]) if (gq[k] == 0) gz++;
        chk("starve_fill_slots", gz, 20);
        for (int k = 0; k < 48; k++)
            chk($sformatf("starve_pat%0d", k), (k < gq.size()) ? gq[k] : -1, ((k % 16) == 15) ? 0 : 1);
        chk("starve_done", obs_donec, 1);

        // Abort after 20 fill writes.
        clr_obs();
        fill_x0 = 0; fill_y0 = 0; fill_x1 = 9; fill_y1 = 9; fill_color = 12'h00A;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        n = 0;
        while (obs_wc < 19 && n < 100) begin
            tick();
            n++;
        end
        chk("abort_reach19", obs_wc, 19);
        fill_abort = 1'b1;
        tick();
        fill_abort = 1'b0;
        chk("abort_busy_next", fill_busy, 0);
        repeat (5) tick();
        chk("abort_writes", obs_wc, 20);
        chk("abort_no_done", obs_donec, 0);
        clr_obs();
        run_fill(1, 1, 2, 1, 'h00F, 100);
        chk("after_abort_count", obs_wc, 2);
        chk("after_abort_done", obs_donec, 1);

        // Start and abort together in IDLE: start wins.
        clr_obs();
        fill_abort = 1'b1;
        fill_x0 = 3; fill_y0 = 3; fill_x1 = 4; fill_y1 = 3; fill_color = 12'h0C0;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        fill_abort = 1'b0;
        repeat (5) tick();
        chk("start_abort_count", obs_wc, 2);
        chk("start_abort_done", obs_donec, 1);

        // Asynchronous reset mid-fill.
        fill_x0 = 0; fill_y0 = 0; fill_x1 = 9; fill_y1 = 9; fill_color = 12'hE0E;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        mdl_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clr_obs();
        repeat (4) tick();
        chk("rst_no_writes", obs_wc, 0);
        chk("rst_no_done", obs_donec, 0);

        // Full-screen clear.
        clr_obs();
        run_fill(0, 0, 255, 255, 'h000, 70000);
        chk("clear_count", obs_wc, 65536);
        chk("clear_first", obs_first, 'h0000);
        chk("clear_last", obs_last, 'hFFFF);
        chk("clear_done", obs_donec, 1);
        repeat (3) tick();
        chk("clear_no_extra", obs_wc, 65536);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (!(pen_we && !last_pg)) begin
                pen_we   = ($urandom_range(0, 99) < 55);
                pen_addr = 16'($urandom);
                pen_data = 12'($urandom);
            end
            fill_start = ($urandom_range(0, 99) < 8);
            if (fill_start) begin
                n = int'($urandom_range(0, 255));
                fill_x0 = 8'(n);
                fill_x1 = 8'(clamp8(n + int'($urandom_range(0, 8)) - 4));
                n = int'($urandom_range(0, 255));
                fill_y0 = 8'(n);
                fill_y1 = 8'(clamp8(n + int'($urandom_range(0, 8)) - 4));
                fill_color = 12'($urandom);
            end
            fill_abort = ($urandom_range(0, 199) < 2);
            tick();
        end
        pen_we = 1'b0; fill_start = 1'b0; fill_abort = 1'b0;
        repeat (100) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
